ram_fifo_ctrl: RTL and testbench

//  FIFO controller sitting directly upstream of the 1 KB single-port byte RAM
//  (mem_1kb_ram). Accepts a byte stream over valid/ready, drives the RAM's
//  en/address/datain, and returns the bytes in order over valid/ready using the RAM's

---
 rtl/ram_fifo_ctrl_if.sv | 23 ++
 rtl/ram_fifo_ctrl.sv | 127 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Byte-stream handshake bundle between producer/consumer and the RAM FIFO controller.
interface ram_fifo_ctrl_if #(
  parameter int DW = 8
);
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;

  // controller side
  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );

  // producer/consumer side
  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port byte RAM with registered read data.
// One RAM op per cycle. Write/read contention is arbitrated by a toggling
// priority bit. Reads land in a 2-entry in-order output buffer, so total
// capacity is DEPTH + 2.
module ram_fifo_ctrl #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_fifo_ctrl_if.slave strm,
  output logic          ram_en,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_datain,
  input  logic [DW-1:0] ram_dataout,
  output logic [AW:0]   ram_level,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [1:0]    obuf_cnt_q, obuf_cnt_d;
  logic [DW-1:0] obuf0_q, obuf0_d;   // head, drives rd_data
  logic [DW-1:0] obuf1_q, obuf1_d;
  logic          rd_pend_q, rd_pend_d;
  logic          prio_q, prio_d;     // 0 = write wins a contested cycle, 1 = read

  logic wr_want, rd_want, wr_ready, wr_fire, rd_issue, pop, rd_valid;
  logic [2:0] obuf_claim;

  // Arbitration and RAM drive; rd_want uses registered state only so
  // rd_ready never reaches wr_ready combinationally.
  always_comb begin
    full       = (level_q == DEPTH_L);
    empty      = (level_q == '0) && !rd_pend_q && (obuf_cnt_q == 2'd0);
    obuf_claim = {1'b0, obuf_cnt_q} + {2'b00, rd_pend_q};
    wr_want    = strm.wr_valid && !full;
    rd_want    = (level_q != '0) && (obuf_claim < 3'd2);
    wr_ready   = rst_n && !full && (!rd_want || !prio_q);
    wr_fire    = strm.wr_valid && wr_ready;
    rd_issue   = rd_want && !wr_fire;
    rd_valid   = (obuf_cnt_q != 2'd0);
    pop        = rd_valid && strm.rd_ready;
    ram_en      = wr_fire;
    ram_address = wr_fire ? wr_ptr_q : rd_ptr_q;
    ram_datain  = strm.wr_data;
  end

  assign strm.wr_ready = wr_ready;
  assign strm.rd_valid = rd_valid;
  assign strm.rd_data  = obuf0_q;
  assign ram_level     = level_q;

  // Pointer, level, pending-read and priority next state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_pend_d = rd_issue;
    prio_d    = prio_q ^ (wr_want && rd_want);
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      level_d  = level_q + 1'b1;
    end else if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      level_d  = level_q - 1'b1;
    end
  end

  // Output buffer: capture the RAM word one cycle after issue, pop from head.
  always_comb begin
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    obuf_cnt_d = obuf_cnt_q;
    case (obuf_cnt_q)
      2'd0: begin
        if (rd_pend_q) begin
          obuf0_d    = ram_dataout;
          obuf_cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (rd_pend_q && pop) begin
          obuf0_d = ram_dataout;
        end else if (rd_pend_q) begin
          obuf1_d    = ram_dataout;
          obuf_cnt_d = 2'd2;
        end else if (pop) begin
          obuf_cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          obuf0_d = obuf1_q;
          if (rd_pend_q) obuf1_d = ram_dataout;
          else           obuf_cnt_d = 2'd1;
        end
      end
    endcase
  end

  // State registers; reset discards everything including an in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      obuf_cnt_q <= 2'd0;
      obuf0_q    <= '0;
      obuf1_q    <= '0;
      rd_pend_q  <= 1'b0;
      prio_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      obuf_cnt_q <= obuf_cnt_d;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
      rd_pend_q  <= rd_pend_d;
      prio_q     <= prio_d;
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, queue-based FIFO reference model,
// directed steps plus randomized streaming.
`timescale 1ns/1ps
module tb_ram_fifo_ctrl;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_en;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_datain;
  logic [DW-1:0] ram_dataout = '0;
  logic [AW:0]   ram_level;
  logic          full, empty;

  ram_fifo_ctrl_if #(.DW(DW)) sif ();

  ram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .strm(sif),
    .ram_en(ram_en), .ram_address(ram_address), .ram_datain(ram_datain),
    .ram_dataout(ram_dataout), .ram_level(ram_level), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // 1 KB single-port RAM, registered read
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (ram_en) mem[ram_address] <= ram_datain;
    else        ram_dataout <= mem[ram_address];
  end

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];
  bit last_wf, last_pop;
  bit exp_en [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int exp_ad [6] = '{0, 1, 0, 2, 1, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sample at the falling edge and update the reference model
  task automatic smp();
    @(negedge clk);
    last_wf  = sif.wr_valid && sif.wr_ready;
    last_pop = sif.rd_valid && sif.rd_ready;
    if (last_pop) begin
      chk("rd_nonphantom", q.size() != 0, 1);
      if (q.size() != 0) chk("rd_data", sif.rd_data, q.pop_front());
    end
    if (last_wf) q.push_back(sif.wr_data);
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic cyc();
    smp(); adv();
  endtask

  task automatic drain(input string tag);
    int c;
    sif.wr_valid = 1'b0; sif.rd_ready = 1'b1;
    for (c = 0; c < 3000 && q.size() != 0; c++) cyc();
    chk({tag, "_drained"}, q.size(), 0);
    cyc();
    chk({tag, "_empty"}, empty, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sif.wr_valid = 1'b0; sif.rd_ready = 1'b0; sif.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    adv();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wi, cnt_in, pops, got, c;
    logic [7:0] d0;
    logic [AW:0] lvl0;
    logic [AW-1:0] a0;

    sif.wr_valid = 1'b0; sif.rd_ready = 1'b0; sif.wr_data = '0;
    // reset state, checked while rst_n is low with a write offered
    #12;
    sif.wr_valid = 1'b1;
    #1;
    chk("rst_wr_ready", sif.wr_ready, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_rd_valid", sif.rd_valid, 0);
    chk("rst_rd_data", sif.rd_data, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", ram_level, 0);
    do_reset();

    // single byte: write cycle 0, read issue cycle 1, rd_valid cycle 3
    sif.rd_ready = 1'b1; sif.wr_valid = 1'b1; sif.wr_data = 8'hA5;
    smp();
    chk("t1_c0_en", ram_en, 1);
    chk("t1_c0_addr", ram_address, 0);
    chk("t1_c0_din", ram_datain, 8'hA5);
    adv();
    sif.wr_valid = 1'b0;
    smp();
    chk("t1_c1_en", ram_en, 0);
    chk("t1_c1_addr", ram_address, 0);
    chk("t1_c1_empty", empty, 0);
    adv();
    smp();
    chk("t1_c2_rd_valid", sif.rd_valid, 0);
    adv();
    smp();
    chk("t1_c3_rd_valid", sif.rd_valid, 1);
    chk("t1_c3_rd_data", sif.rd_data, 8'hA5);
    adv();
    smp();
    chk("t1_empty_after_pop", empty, 1);
    adv();

    // fill: 1026 bytes with consumer stalled
    sif.rd_ready = 1'b0; wi = 0;
    for (c = 0; c < 4000 && wi < 1026; c++) begin
      sif.wr_valid = 1'b1; sif.wr_data = wi[7:0];
      smp();
      if (last_wf) wi++;
      adv();
    end
    chk("t2_accepted", wi, 1026);
    sif.wr_data = 8'hEE;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("t2_full", full, 1);
      chk("t2_level", ram_level, 1024);
      chk("t2_wr_ready", sif.wr_ready, 0);
      chk("t2_held_en", ram_en, 0);
      chk("t2_rd_valid", sif.rd_valid, 1);
      adv();
    end
    sif.wr_valid = 1'b0; sif.rd_ready = 1'b1; pops = 0;
    for (c = 0; c < 3000 && q.size() != 0; c++) begin
      smp();
      if (last_pop) pops++;
      adv();
    end
    chk("t2_pops", pops, 1026);
    cyc();
    chk("t2_empty", empty, 1);

    // contention from reset: prio starts at write
    do_reset();
    sif.rd_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sif.wr_valid = 1'b1; sif.wr_data = 8'($urandom);
      smp();
      chk("t4_en", ram_en, 32'(exp_en[k]));
      chk("t4_addr", ram_address, exp_ad[k]);
      adv();
    end

    // back-pressure: output buffer saturates, no further reads
    sif.wr_valid = 1'b0;
    repeat (4) cyc();
    smp();
    chk("t5_rd_valid", sif.rd_valid, 1);
    chk("t5_level", ram_level, q.size() - 2);
    d0 = sif.rd_data; lvl0 = ram_level; a0 = ram_address;
    adv();
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("t5_rd_data_stable", sif.rd_data, d0);
      chk("t5_no_issue_en", ram_en, 0);
      chk("t5_no_issue_addr", ram_address, a0);
      chk("t5_level_stable", ram_level, lvl0);
      adv();
    end
    drain("t5");

    // random streaming across pointer wrap
    cnt_in = 0;
    for (c = 0; c < 30000 && cnt_in < 3000; c++) begin
      sif.wr_valid = (cnt_in < 3000) && ($urandom_range(0, 3) != 0);
      sif.wr_data  = 8'($urandom);
      sif.rd_ready = $urandom_range(0, 1) == 1;
      smp();
      chk("t3_level_max", ram_level <= 11'd1024, 1);
      if (last_wf) cnt_in++;
      adv();
    end
    chk("t3_written", cnt_in, 3000);
    drain("t3");

    // async reset mid-stream, then fresh byte must come out first
    sif.rd_ready = 1'b0; wi = 0;
    for (c = 0; c < 100 && wi < 10; c++) begin
      sif.wr_valid = 1'b1; sif.wr_data = 8'($urandom);
      smp();
      if (last_wf) wi++;
      adv();
    end
    sif.rd_ready = 1'b1;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rd_valid", sif.rd_valid, 0);
    chk("t6_level", ram_level, 0);
    chk("t6_empty", empty, 1);
    chk("t6_wr_ready", sif.wr_ready, 0);
    chk("t6_ram_en", ram_en, 0);
    q.delete();
    sif.wr_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    adv();
    sif.wr_valid = 1'b1; sif.wr_data = 8'h3C; sif.rd_ready = 1'b1;
    cyc();
    sif.wr_valid = 1'b0;
    got = 0;
    for (c = 0; c < 10 && got == 0; c++) begin
      smp();
      if (last_pop) begin
        got = 1;
        chk("t6_first_byte", sif.rd_data, 8'h3C);
      end
      adv();
    end
    chk("t6_got_byte", got, 1);
    cyc();
    chk("t6_empty_end", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
